key_action: RTL and testbench
=============================

Name: key_action

Overview:
- Downstream consumer of the PS/2 key-level driver; converts its raw 4-bit held-key vector into per-frame game commands for the player-physics logic.
- Synchronises the key levels and detects edges every clk cycle. Events are latched until the next frame_tick, then issued as a registered command set.
- Resolves left/right conflicts and tracks jump-hold duration, which gives variable jump height.

Parameters:
- HOLD_MAX, 15: frame count at which the jump-hold counter saturates; jump_cut is suppressed once reached. Range 1..15.
- SYNC_STAGES, 2: flip-flop stages on keys before use. Minimum 2.

Ports:
- clk  input  1  system clock; all logic on posedge.
- rst  input  1  asynchronous, active-high reset.
- keys  input  4  raw held levels from the PS/2 driver, not synchronous to clk: [0]=A left, [1]=D right, [2]=W shoot, [3]=Space jump.
- frame_tick  input  1  one-cycle pulse per game frame.
- move_dir  output  2  00 none, 01 left, 10 right; 11 never driven.
- jump_req  output  1  one-cycle pulse: jump pressed during the last frame.
- jump_cut  output  1  one-cycle pulse: jump released before the hold saturated.
- jump_hold  output  4  frames the jump key has been held; saturates at HOLD_MAX.
- shoot_req  output  1  one-cycle pulse: shoot pressed during the last frame.

Behaviour:
- Reset (async, rst=1):
  - All outputs 0; sync chains 0; sticky flags cleared; jump FSM to IDLE; last-direction register = none.
  - Deasserting rst mid-frame starts a clean frame. Nothing latched before reset is ever reported.
- Synchronisation:
  - keys passes through SYNC_STAGES flops giving ks.
  - Edge detect against a one-cycle-delayed copy: rise = ks & ~ks_d, fall = ~ks & ks_d.
- Sticky event flags (set on any clk cycle):
  - jp_seen set on rise[3]; jr_seen set on fall[3]; sh_seen set on rise[2].
  - Multiple presses within one frame count as one event.
  - Cleared on the cycle frame_tick=1, after being sampled. An edge that coincides with frame_tick belongs to the current frame, so the flag is sampled as (flag | edge).
- Output timing:
  - All outputs update on the posedge where frame_tick=1 and are visible the cycle after.
  - Pulses (jump_req, jump_cut, shoot_req) last exactly one clk cycle.
  - move_dir and jump_hold hold their value until the next frame_tick.
- Direction:
  - The last-pressed register updates on rise[0] (left) or rise[1] (right). If both rise in the same cycle, right wins.
  - At frame_tick: only A held gives 01; only D held gives 10; both held gives the last-pressed direction; neither held gives 00.
  - If the last-pressed key is released while the other stays held, the still-held key's direction applies.
- Jump FSM (evaluated at frame_tick only):
  - IDLE:
    - If press seen and key still held: jump_req=1, jump_hold=1, go to HELD.
    - If press seen and already released (tap within one frame): jump_req=1 and jump_cut=1 in the same cycle, jump_hold=0, stay IDLE.
  - HELD:
    - Key released (jr_seen or ks[3]=0): jump_cut=1, jump_hold=0, go to IDLE.
    - Otherwise jump_hold+1. On reaching HOLD_MAX go to SAT.
  - SAT:
    - jump_hold stays at HOLD_MAX.
    - On release: jump_hold=0, no jump_cut, go to IDLE.
  - A release followed by a re-press within one frame while in HELD/SAT: jump_cut (HELD only), then jump_req, both asserted; next state HELD, jump_hold=1.
- Shoot: shoot_req = sh_seen at frame_tick. Holding W does not auto-repeat.
- No frame_tick: flags accumulate indefinitely, with no loss and no duplication.

Test Plan:
- Reset mid-frame with jp_seen set, then release rst -> no jump_req on the next frame_tick; all outputs 0.
- Hold A, then press D 5 cycles later, hold both across a frame_tick -> move_dir=10. Release D, next tick -> move_dir=01.
- Press Space, hold 20 frames, HOLD_MAX=15 -> jump_req at frame 1; jump_hold 1..15 then stays at 15; on release no jump_cut, jump_hold=0.
- Press Space, release after 3 frame_ticks -> jump_req, jump_hold=1,2,3, then jump_cut on the 4th tick with jump_hold=0.
- Tap Space (press+release) between two frame_ticks -> jump_req=1 and jump_cut=1 in the same cycle; FSM stays IDLE.
- Press W three times within one frame, then frame_tick -> exactly one shoot_req pulse. A press coincident with frame_tick is reported on that tick.

Source files
------------

// File: rtl/key_action.sv
// Converts synchronised PS/2 held-key levels into per-frame game commands:
// movement direction, jump request/cut/hold duration and shoot request.
module key_action #(
  parameter int unsigned HOLD_MAX    = 15,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] keys,
  input  logic       frame_tick,
  output logic [1:0] move_dir,
  output logic       jump_req,
  output logic       jump_cut,
  output logic [3:0] jump_hold,
  output logic       shoot_req
);

  localparam logic [3:0] HOLD_MAX_L = 4'(HOLD_MAX);

  typedef enum logic [1:0] {IDLE = 2'd0, HELD = 2'd1, SAT = 2'd2} jstate_e;
  typedef enum logic [1:0] {DIR_NONE = 2'b00, DIR_LEFT = 2'b01, DIR_RIGHT = 2'b10} dir_e;

  logic [SYNC_STAGES-1:0][3:0] sync_q;
  logic [3:0] ks, ks_d_q, rise, fall;
  logic       jp_q, jp_d, jr_q, jr_d, sh_q, sh_d;
  dir_e       last_q, last_d;
  jstate_e    state_q, state_d;
  logic [1:0] move_dir_q, move_dir_d;
  logic       jump_req_q, jump_req_d, jump_cut_q, jump_cut_d, shoot_q, shoot_d;
  logic [3:0] hold_q, hold_d, hold_inc;
  logic       pressed, released, release_now;

  assign ks        = sync_q[SYNC_STAGES-1];
  assign move_dir  = move_dir_q;
  assign jump_req  = jump_req_q;
  assign jump_cut  = jump_cut_q;
  assign jump_hold = hold_q;
  assign shoot_req = shoot_q;

  // Synchroniser, edge-detect history and all frame state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q     <= '0;
      ks_d_q     <= '0;
      jp_q       <= 1'b0;
      jr_q       <= 1'b0;
      sh_q       <= 1'b0;
      last_q     <= DIR_NONE;
      state_q    <= IDLE;
      move_dir_q <= 2'b00;
      jump_req_q <= 1'b0;
      jump_cut_q <= 1'b0;
      shoot_q    <= 1'b0;
      hold_q     <= 4'd0;
    end else begin
      sync_q     <= {sync_q[SYNC_STAGES-2:0], keys};
      ks_d_q     <= ks;
      jp_q       <= jp_d;
      jr_q       <= jr_d;
      sh_q       <= sh_d;
      last_q     <= last_d;
      state_q    <= state_d;
      move_dir_q <= move_dir_d;
      jump_req_q <= jump_req_d;
      jump_cut_q <= jump_cut_d;
      shoot_q    <= shoot_d;
      hold_q     <= hold_d;
    end
  end

  // Event latching, direction resolution and jump FSM.
  always_comb begin
    rise        = ks & ~ks_d_q;
    fall        = ~ks & ks_d_q;
    jp_d        = jp_q | rise[3];
    jr_d        = jr_q | fall[3];
    sh_d        = sh_q | rise[2];
    last_d      = last_q;
    state_d     = state_q;
    move_dir_d  = move_dir_q;
    jump_req_d  = 1'b0;
    jump_cut_d  = 1'b0;
    shoot_d     = 1'b0;
    hold_d      = hold_q;
    hold_inc    = hold_q + 4'd1;
    pressed     = jp_d;
    released    = jr_d;
    release_now = jr_d | ~ks[3];

    if (rise[1])      last_d = DIR_RIGHT;
    else if (rise[0]) last_d = DIR_LEFT;

    if (frame_tick) begin
      jp_d    = 1'b0;
      jr_d    = 1'b0;
      sh_d    = 1'b0;
      shoot_d = sh_q | rise[2];

      case (ks[1:0])
        2'b01:   move_dir_d = DIR_LEFT;
        2'b10:   move_dir_d = DIR_RIGHT;
        2'b11:   move_dir_d = last_d;
        default: move_dir_d = DIR_NONE;
      endcase

      case (state_q)
        IDLE: begin
          if (pressed) begin
            jump_req_d = 1'b1;
            if (ks[3]) begin
              hold_d  = 4'd1;
              state_d = (HOLD_MAX == 1) ? SAT : HELD;
            end else begin
              jump_cut_d = 1'b1;
              hold_d     = 4'd0;
            end
          end
        end
        HELD, SAT: begin
          if (release_now || released) begin
            jump_cut_d = (state_q == HELD);
            jump_req_d = pressed;
            // A re-press inside the frame starts a fresh hold; a re-tap is a cut jump.
            if (pressed && ks[3]) begin
              hold_d  = 4'd1;
              state_d = (HOLD_MAX == 1) ? SAT : HELD;
            end else begin
              jump_cut_d = jump_cut_d | pressed;
              hold_d     = 4'd0;
              state_d    = IDLE;
            end
          end else if (state_q == HELD) begin
            hold_d = hold_inc;
            if (hold_inc == HOLD_MAX_L) state_d = SAT;
          end
        end
        default: begin
          state_d = IDLE;
          hold_d  = 4'd0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_key_action.sv
// Self-checking bench for key_action: directed scenarios plus randomized
// key/frame traffic against a frame-level behavioural model.
module tb_key_action;

  localparam int unsigned HOLD_MAX    = 15;
  localparam int unsigned SYNC_STAGES = 2;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] keys;
  logic       frame_tick;
  logic [1:0] move_dir;
  logic       jump_req, jump_cut, shoot_req;
  logic [3:0] jump_hold;

  int checks = 0;
  int errors = 0;

  // Model state: key history, frame events and expected outputs.
  logic [3:0] hist [SYNC_STAGES+1];
  bit   ev_jp, ev_jr, ev_sh;
  int   last_dir;
  int   m_hold;
  logic [1:0] e_dir;
  logic e_req, e_cut, e_shoot;

  key_action #(.HOLD_MAX(HOLD_MAX), .SYNC_STAGES(SYNC_STAGES)) dut (
    .clk(clk), .rst(rst), .keys(keys), .frame_tick(frame_tick),
    .move_dir(move_dir), .jump_req(jump_req), .jump_cut(jump_cut),
    .jump_hold(jump_hold), .shoot_req(shoot_req)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    for (int i = 0; i <= SYNC_STAGES; i++) hist[i] = 4'h0;
    ev_jp = 0; ev_jr = 0; ev_sh = 0;
    last_dir = 0; m_hold = 0;
    e_dir = 2'b00; e_req = 0; e_cut = 0; e_shoot = 0;
  endtask

  // Levels used by the DUT lag the driven keys by SYNC_STAGES cycles.
  task automatic model_step(input logic [3:0] k, input logic t);
    logic [3:0] ks, kp, r, f;
    bit pressed, released, shot;
    ks = hist[SYNC_STAGES-1];
    kp = hist[SYNC_STAGES];
    r  = ks & ~kp;
    f  = ~ks & kp;
    if (r[1]) last_dir = 2;
    else if (r[0]) last_dir = 1;
    if (t) begin
      pressed  = ev_jp || r[3];
      released = ev_jr || f[3];
      shot     = ev_sh || r[2];
      ev_jp = 0; ev_jr = 0; ev_sh = 0;
      e_shoot = shot;
      if (ks[0] && ks[1])  e_dir = 2'(last_dir);
      else if (ks[0])      e_dir = 2'b01;
      else if (ks[1])      e_dir = 2'b10;
      else                 e_dir = 2'b00;
      e_req = 0; e_cut = 0;
      if (m_hold == 0) begin
        if (pressed) begin
          e_req = 1;
          if (ks[3]) m_hold = 1;
          else e_cut = 1;
        end
      end else if (released || !ks[3]) begin
        e_cut = (m_hold < int'(HOLD_MAX));
        if (pressed) e_req = 1;
        if (pressed && ks[3]) m_hold = 1;
        else begin
          if (pressed) e_cut = 1;
          m_hold = 0;
        end
      end else if (m_hold < int'(HOLD_MAX)) begin
        m_hold = m_hold + 1;
      end
    end else begin
      e_req = 0; e_cut = 0; e_shoot = 0;
      ev_jp = ev_jp || r[3];
      ev_jr = ev_jr || f[3];
      ev_sh = ev_sh || r[2];
    end
    for (int i = SYNC_STAGES; i > 0; i--) hist[i] = hist[i-1];
    hist[0] = k;
  endtask

  task automatic cycle(input logic [3:0] k, input logic t);
    @(negedge clk);
    keys = k;
    frame_tick = t;
    @(posedge clk);
    model_step(k, t);
    #1;
  endtask

  task automatic frame(input logic [3:0] k, input int n);
    for (int i = 1; i < n; i++) cycle(k, 1'b0);
    cycle(k, 1'b1);
  endtask

  task automatic do_reset();
    @(negedge clk);
    keys = 4'h0;
    frame_tick = 1'b0;
    #2 rst = 1'b1;
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; keys = 4'h0; frame_tick = 1'b0;
    model_reset();
    #1;
    checks++; if (move_dir !== 2'b00) begin errors++; $display("FAIL reset_dir got %b want 00", move_dir); end
    checks++; if (jump_req !== 1'b0) begin errors++; $display("FAIL reset_req got %b want 0", jump_req); end
    checks++; if (jump_cut !== 1'b0) begin errors++; $display("FAIL reset_cut got %b want 0", jump_cut); end
    checks++; if (jump_hold !== 4'd0) begin errors++; $display("FAIL reset_hold got %0d want 0", jump_hold); end
    checks++; if (shoot_req !== 1'b0) begin errors++; $display("FAIL reset_shoot got %b want 0", shoot_req); end
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset_midframe();
    repeat (4) cycle(4'b0001, 1'b0);
    cycle(4'b0001, 1'b1);
    checks++; if (move_dir !== 2'b01) begin errors++; $display("FAIL pre_reset_dir got %b want 01", move_dir); end
    repeat (4) cycle(4'b1001, 1'b0);
    do_reset();
    checks++; if (move_dir !== 2'b00) begin errors++; $display("FAIL midreset_dir got %b want 00", move_dir); end
    repeat (3) cycle(4'h0, 1'b0);
    cycle(4'h0, 1'b1);
    checks++; if (jump_req !== 1'b0) begin errors++; $display("FAIL post_reset_req got %b want 0", jump_req); end
    checks++; if (jump_hold !== 4'd0) begin errors++; $display("FAIL post_reset_hold got %0d want 0", jump_hold); end
  endtask

  task automatic test_direction();
    repeat (5) cycle(4'b0001, 1'b0);
    frame(4'b0011, 5);
    checks++; if (move_dir !== 2'b10) begin errors++; $display("FAIL dir_both got %b want 10", move_dir); end
    cycle(4'b0001, 1'b0);
    checks++; if (move_dir !== 2'b10) begin errors++; $display("FAIL dir_hold got %b want 10", move_dir); end
    frame(4'b0001, 5);
    checks++; if (move_dir !== 2'b01) begin errors++; $display("FAIL dir_release_d got %b want 01", move_dir); end
    frame(4'b0000, 5);
    checks++; if (move_dir !== 2'b00) begin errors++; $display("FAIL dir_none got %b want 00", move_dir); end
  endtask

  task automatic test_jump_saturate();
    repeat (4) cycle(4'b1000, 1'b0);
    for (int fr = 1; fr <= 20; fr++) begin
      frame(4'b1000, 4);
      checks++;
      if (jump_req !== (fr == 1)) begin errors++; $display("FAIL sat_req frame %0d got %b want %b", fr, jump_req, fr == 1); end
      checks++;
      if (jump_hold !== 4'((fr < 15) ? fr : 15)) begin errors++; $display("FAIL sat_hold frame %0d got %0d want %0d", fr, jump_hold, (fr < 15) ? fr : 15); end
      if (fr == 1) begin
        cycle(4'b1000, 1'b0);
        checks++; if (jump_req !== 1'b0) begin errors++; $display("FAIL sat_req_pulse got %b want 0", jump_req); end
      end
    end
    frame(4'b0000, 4);
    checks++; if (jump_cut !== 1'b0) begin errors++; $display("FAIL sat_release_cut got %b want 0", jump_cut); end
    checks++; if (jump_hold !== 4'd0) begin errors++; $display("FAIL sat_release_hold got %0d want 0", jump_hold); end
  endtask

  task automatic test_jump_cut();
    for (int fr = 1; fr <= 3; fr++) begin
      frame(4'b1000, 4);
      checks++; if (jump_hold !== 4'(fr)) begin errors++; $display("FAIL cut_hold frame %0d got %0d want %0d", fr, jump_hold, fr); end
    end
    frame(4'b0000, 4);
    checks++; if (jump_cut !== 1'b1) begin errors++; $display("FAIL cut_pulse got %b want 1", jump_cut); end
    checks++; if (jump_hold !== 4'd0) begin errors++; $display("FAIL cut_hold_zero got %0d want 0", jump_hold); end
    cycle(4'b0000, 1'b0);
    checks++; if (jump_cut !== 1'b0) begin errors++; $display("FAIL cut_pulse_len got %b want 0", jump_cut); end
  endtask

  task automatic test_tap();
    repeat (2) cycle(4'b1000, 1'b0);
    repeat (4) cycle(4'b0000, 1'b0);
    cycle(4'b0000, 1'b1);
    checks++; if (jump_req !== 1'b1 || jump_cut !== 1'b1) begin errors++; $display("FAIL tap_req_cut got %b%b want 11", jump_req, jump_cut); end
    checks++; if (jump_hold !== 4'd0) begin errors++; $display("FAIL tap_hold got %0d want 0", jump_hold); end
    frame(4'b0000, 4);
    checks++; if (jump_req !== 1'b0 || jump_cut !== 1'b0) begin errors++; $display("FAIL tap_idle got %b%b want 00", jump_req, jump_cut); end
  endtask

  task automatic test_shoot();
    for (int i = 0; i < 3; i++) begin
      repeat (2) cycle(4'b0100, 1'b0);
      repeat (2) cycle(4'b0000, 1'b0);
    end
    cycle(4'b0000, 1'b1);
    checks++; if (shoot_req !== 1'b1) begin errors++; $display("FAIL shoot_once got %b want 1", shoot_req); end
    cycle(4'b0000, 1'b0);
    checks++; if (shoot_req !== 1'b0) begin errors++; $display("FAIL shoot_pulse got %b want 0", shoot_req); end
    frame(4'b0000, 4);
    checks++; if (shoot_req !== 1'b0) begin errors++; $display("FAIL shoot_dup got %b want 0", shoot_req); end
    // Rising edge reaches the edge detector exactly on the tick cycle.
    cycle(4'b0100, 1'b0);
    cycle(4'b0100, 1'b0);
    cycle(4'b0100, 1'b1);
    checks++; if (shoot_req !== 1'b1) begin errors++; $display("FAIL shoot_coincident got %b want 1", shoot_req); end
    frame(4'b0100, 6);
    checks++; if (shoot_req !== 1'b0) begin errors++; $display("FAIL shoot_norepeat got %b want 0", shoot_req); end
    repeat (2) cycle(4'b0000, 1'b0);
    cycle(4'b0100, 1'b0);
    repeat (200) cycle(4'b0000, 1'b0);
    cycle(4'b0000, 1'b1);
    checks++; if (shoot_req !== 1'b1) begin errors++; $display("FAIL shoot_accumulate got %b want 1", shoot_req); end
  endtask

  task automatic test_random();
    logic [3:0] k;
    int gap;
    k = 4'h0;
    gap = 0;
    for (int n = 0; n < 4000; n++) begin
      for (int b = 0; b < 4; b++)
        if ($urandom_range(0, 9) == 0) k[b] = ~k[b];
      if (gap == 0) gap = $urandom_range(1, 12);
      gap--;
      cycle(k, gap == 0);
      checks++;
      if (move_dir !== e_dir || jump_req !== e_req || jump_cut !== e_cut ||
          jump_hold !== 4'(m_hold) || shoot_req !== e_shoot) begin
        errors++;
        $display("FAIL random cycle %0d got dir=%b req=%b cut=%b hold=%0d shoot=%b want dir=%b req=%b cut=%b hold=%0d shoot=%b",
                 n, move_dir, jump_req, jump_cut, jump_hold, shoot_req,
                 e_dir, e_req, e_cut, m_hold, e_shoot);
      end
    end
  endtask

  initial begin
    test_reset();
    test_reset_midframe();
    test_direction();
    test_jump_saturate();
    test_jump_cut();
    test_tap();
    test_shoot();
    do_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
